// File: rtl/zbb_pkg.sv
// rtl/zbb_pkg.sv - shared constants, op encodings and FSM states for the Zbb count unit
package zbb_pkg;

    localparam int XLEN    = 32;
    localparam int COUNT_W = 6;

    localparam logic [1:0] OP_CLZ  = 2'b00;
    localparam logic [1:0] OP_CTZ  = 2'b01;
    localparam logic [1:0] OP_CPOP = 2'b10;
    localparam logic [1:0] OP_RSVD = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_ENC  = 2'b01,
        S_POP  = 2'b10,
        S_DONE = 2'b11
    } state_t;

endpackage

// File: rtl/clz_encoder.sv
// rtl/clz_encoder.sv - 32-bit leading-zero count, all-zero input yields 32
module clz_encoder (
    input  logic [31:0] in_i,
    output logic [5:0]  out_o
);

    // Scan upward so the highest set bit makes the final assignment.
    always_comb begin
        out_o = 6'd32;
        for (int i = 0; i < 32; i++) begin
            if (in_i[i]) begin
                out_o = 6'(31 - i);
            end
        end
    end

endmodule

// File: rtl/popcnt_chunk.sv
// rtl/popcnt_chunk.sv - set-bit count of one cpop slice
module popcnt_chunk
    import zbb_pkg::*;
#(
    parameter int W = 8
) (
    input  logic [W-1:0]       data_i,
    output logic [COUNT_W-1:0] count_o
);

    // Plain adder chain; the slice is narrow enough that depth is not a concern.
    always_comb begin
        count_o = '0;
        for (int i = 0; i < W; i++) begin
            count_o = count_o + COUNT_W'(data_i[i]);
        end
    end

endmodule

// File: rtl/zbb_count_unit.sv
// rtl/zbb_count_unit.sv - multi-cycle clz/ctz/cpop functional unit with valid/ready and kill
module zbb_count_unit #(
    parameter int XLEN      = 32,
    parameter int POP_CHUNK = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            valid_i,
    output logic            ready_o,
    input  logic [1:0]      op_i,
    input  logic [XLEN-1:0] operand_i,
    input  logic            kill_i,
    output logic            valid_o,
    input  logic            ready_i,
    output logic [XLEN-1:0] result_o
);
    import zbb_pkg::*;

    localparam int NCHUNK = XLEN / POP_CHUNK;
    localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    state_t              state_q, state_d;
    logic [XLEN-1:0]     opnd_q, opnd_d;
    logic [XLEN-1:0]     result_q, result_d;
    logic [COUNT_W-1:0]  acc_q, acc_d;
    logic [IDX_W-1:0]    idx_q, idx_d;

    logic [XLEN-1:0]     opnd_rev;
    logic [5:0]          enc_out;
    logic [POP_CHUNK-1:0] chunk;
    logic [COUNT_W-1:0]  chunk_cnt;
    logic [COUNT_W-1:0]  pop_sum;

    // ctz reuses the leading-zero encoder by reversing the operand on capture.
    always_comb begin
        opnd_rev = '0;
        for (int i = 0; i < XLEN; i++) begin
            opnd_rev[i] = operand_i[XLEN-1-i];
        end
    end

    clz_encoder u_clz_encoder (
        .in_i  (opnd_q),
        .out_o (enc_out)
    );

    assign chunk = opnd_q[int'(idx_q)*POP_CHUNK +: POP_CHUNK];

    popcnt_chunk #(
        .W (POP_CHUNK)
    ) u_popcnt_chunk (
        .data_i  (chunk),
        .count_o (chunk_cnt)
    );

    assign pop_sum  = acc_q + chunk_cnt;
    assign result_o = result_q;
    assign valid_o  = (state_q == S_DONE);
    assign ready_o  = (state_q == S_IDLE) && !rst;

    // Next-state and datapath update; kill overrides every state.
    always_comb begin
        state_d  = state_q;
        opnd_d   = opnd_q;
        result_d = result_q;
        acc_d    = acc_q;
        idx_d    = idx_q;
        if (kill_i) begin
            state_d = S_IDLE;
            acc_d   = '0;
            idx_d   = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (valid_i) begin
                        opnd_d = (op_i == OP_CTZ) ? opnd_rev : operand_i;
                        case (op_i)
                            OP_CLZ, OP_CTZ: state_d = S_ENC;
                            OP_CPOP: begin
                                state_d = S_POP;
                                acc_d   = '0;
                                idx_d   = '0;
                            end
                            default: begin
                                state_d  = S_DONE;
                                result_d = '0;
                            end
                        endcase
                    end
                end
                S_ENC: begin
                    result_d = {{(XLEN-6){1'b0}}, enc_out};
                    state_d  = S_DONE;
                end
                S_POP: begin
                    acc_d = pop_sum;
                    if (idx_q == IDX_W'(NCHUNK - 1)) begin
                        result_d = {{(XLEN-COUNT_W){1'b0}}, pop_sum};
                        idx_d    = '0;
                        state_d  = S_DONE;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
                S_DONE: begin
                    if (ready_i) begin
                        state_d = S_IDLE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // State and datapath registers; reset beats kill.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            opnd_q   <= '0;
            result_q <= '0;
            acc_q    <= '0;
            idx_q    <= '0;
        end else begin
            state_q  <= state_d;
            opnd_q   <= opnd_d;
            result_q <= result_d;
            acc_q    <= acc_d;
            idx_q    <= idx_d;
        end
    end

endmodule

// File: tb/tb_zbb_count_unit.sv
// tb/tb_zbb_count_unit.sv - scoreboard bench for zbb_count_unit with random and directed stimulus
module tb_zbb_count_unit;
    import zbb_pkg::*;

    logic        clk;
    logic        rst;
    logic        valid_i;
    logic        ready_o;
    logic [1:0]  op_i;
    logic [31:0] operand_i;
    logic        kill_i;
    logic        valid_o;
    logic        ready_i;
    logic [31:0] result_o;

    zbb_count_unit #(.XLEN(32), .POP_CHUNK(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .valid_i   (valid_i),
        .ready_o   (ready_o),
        .op_i      (op_i),
        .operand_i (operand_i),
        .kill_i    (kill_i),
        .valid_o   (valid_o),
        .ready_i   (ready_i),
        .result_o  (result_o)
    );

    typedef struct {
        logic [31:0] res;
        int          due;
    } exp_t;

    exp_t sb[$];
    int   n_vec  = 0;
    int   n_fail = 0;
    int   cyc    = 0;
    bit   rdy_rand  = 0;
    bit   rdy_force = 1;

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #1 ready_i = rdy_rand ? 1'($urandom_range(0, 1)) : rdy_force;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%08h), expected %0d (0x%08h) at cycle %0d",
                     name, act, act, exp, exp, cyc);
        end
    endtask

    function automatic logic [31:0] model_res(input logic [1:0] op, input logic [31:0] x);
        int n;
        n = 0;
        case (op)
            OP_CLZ: begin
                for (int i = 31; i >= 0; i--) begin
                    if (x[i]) break;
                    n++;
                end
            end
            OP_CTZ: begin
                for (int i = 0; i < 32; i++) begin
                    if (x[i]) break;
                    n++;
                end
            end
            OP_CPOP: n = $countones(x);
            default: n = 0;
        endcase
        return 32'(n);
    endfunction

    function automatic int model_lat(input logic [1:0] op);
        case (op)
            OP_CLZ, OP_CTZ: return 2;
            OP_CPOP:        return 32 / 8 + 1;
            default:        return 1;
        endcase
    endfunction

    // Monitor: pops one expectation per new result and checks it is held under backpressure.
    bit          expect_new = 1;
    logic [31:0] held;
    always @(negedge clk) begin
        if (rst) begin
            expect_new = 1;
        end else if (valid_o) begin
            if (expect_new) begin
                if (sb.size() == 0) begin
                    chk("unexpected_valid", 32'(valid_o), 32'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("result", result_o, e.res);
                    chk("latency_cycle", 32'(cyc), 32'(e.due));
                end
                held       = result_o;
                expect_new = 0;
            end else begin
                chk("result_hold", result_o, held);
            end
            chk("ready_o_in_done", 32'(ready_o), 32'd0);
            if (ready_i) expect_new = 1;
        end else begin
            expect_new = 1;
        end
    end

    task automatic issue(input logic [1:0] op, input logic [31:0] x, input bit push);
        int n;
        n = 0;
        @(negedge clk);
        while (!ready_o && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!ready_o) begin
            chk("issue_timeout", 32'(ready_o), 32'd1);
            return;
        end
        op_i      = op;
        operand_i = x;
        valid_i   = 1;
        if (push) sb.push_back('{model_res(op, x), cyc + model_lat(op)});
        @(posedge clk);
        #1;
        valid_i   = 0;
        op_i      = 2'($urandom);
        operand_i = $urandom;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        @(negedge clk);
        while ((!ready_o || sb.size() != 0) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) chk("idle_timeout", 32'(sb.size()), 32'd0);
    endtask

    logic [31:0] rx;

    initial begin
        rst = 1; valid_i = 0; op_i = 0; operand_i = 0; kill_i = 0; ready_i = 1;
        repeat (3) @(negedge clk);
        chk("reset_valid_o", 32'(valid_o), 32'd0);
        chk("reset_result_o", result_o, 32'd0);
        chk("reset_ready_o", 32'(ready_o), 32'd0);
        rst = 0;
        @(negedge clk);
        chk("idle_ready_o", 32'(ready_o), 32'd1);

        issue(OP_CLZ, 32'h0001_0000, 1);
        issue(OP_CLZ, 32'h8000_0000, 1);
        issue(OP_CLZ, 32'h0000_0000, 1);
        issue(OP_CTZ, 32'h0000_0100, 1);
        issue(OP_CTZ, 32'h0000_0000, 1);
        issue(OP_CTZ, 32'h8000_0000, 1);

        issue(OP_CPOP, 32'hF0F0_0001, 1);
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            chk("cpop_busy_ready_o", 32'(ready_o), 32'd0);
        end
        issue(OP_CPOP, 32'hFFFF_FFFF, 1);
        issue(OP_CPOP, 32'h0000_0000, 1);
        issue(OP_RSVD, 32'h1234_5678, 1);
        wait_idle();

        // Backpressure on a clz result.
        rdy_force = 0;
        @(posedge clk);
        #2;
        issue(OP_CLZ, 32'h0000_00FF, 1);
        begin
            int n;
            n = 0;
            @(negedge clk);
            while (!valid_o && n < 20) begin
                @(negedge clk);
                n++;
            end
        end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("bp_valid_o", 32'(valid_o), 32'd1);
            chk("bp_result_o", result_o, 32'd24);
        end
        rdy_force = 1;
        @(negedge clk);
        chk("bp_valid_at_release", 32'(valid_o), 32'd1);
        @(negedge clk);
        chk("bp_idle_ready_o", 32'(ready_o), 32'd1);
        chk("bp_idle_valid_o", 32'(valid_o), 32'd0);

        // Kill cpop at cycle 2.
        issue(OP_CPOP, 32'hFFFF_FFFF, 0);
        @(negedge clk);
        @(negedge clk);
        kill_i = 1;
        @(posedge clk);
        #1 kill_i = 0;
        @(negedge clk);
        chk("kill_ready_o", 32'(ready_o), 32'd1);
        chk("kill_valid_o", 32'(valid_o), 32'd0);
        repeat (6) @(negedge clk);
        issue(OP_CPOP, 32'h0000_000F, 1);
        wait_idle();

        // Kill together with a request in IDLE.
        @(negedge clk);
        op_i = OP_CLZ; operand_i = 32'h1; valid_i = 1; kill_i = 1;
        @(posedge clk);
        #1 valid_i = 0; kill_i = 0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("kill_idle_valid_o", 32'(valid_o), 32'd0);
            chk("kill_idle_ready_o", 32'(ready_o), 32'd1);
        end

        // Reset in the middle of a ctz.
        issue(OP_CTZ, 32'h0000_0100, 0);
        @(negedge clk);
        rst = 1;
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("rst_mid_valid_o", 32'(valid_o), 32'd0);
        chk("rst_mid_result_o", result_o, 32'd0);
        chk("rst_mid_ready_o", 32'(ready_o), 32'd0);
        rst = 0;
        issue(OP_CLZ, 32'h0000_0001, 1);
        wait_idle();

        // Random operations under random backpressure.
        rdy_rand = 1;
        for (int t = 0; t < 150; t++) begin
            case ($urandom_range(0, 4))
                0:       rx = 32'h0;
                1:       rx = 32'hFFFF_FFFF;
                2:       rx = 32'h1 << $urandom_range(0, 31);
                3:       rx = $urandom >> $urandom_range(0, 31);
                default: rx = $urandom;
            endcase
            issue(2'($urandom_range(0, 3)), rx, 1);
        end
        wait_idle();
        chk("scoreboard_drained", 32'(sb.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish, got cycle %0d, expected completion", cyc);
        $fatal(1);
    end

endmodule

// File: doc/zbb_count_unit.md
Name: zbb_count_unit

Overview:
- Multi-cycle Zbb count functional unit in the EX stage; executes clz, ctz and cpop on a 32-bit rs1 operand.
- Sits directly upstream of the clz_encoder tree:
  - registers the operand;
  - bit-reverses it for ctz;
  - feeds the encoder;
  - registers the encoder result.
- cpop is computed iteratively, one chunk per cycle, in the same datapath.
- Valid/ready handshake on both sides; kill input for pipeline flush.

Parameters:
- XLEN, 32, operand/result width; only 32 is supported (clz_encoder tree is fixed at 32).
- POP_CHUNK, 8, bits counted per cpop cycle; must divide XLEN; cpop iterations = XLEN/POP_CHUNK.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- valid_i  in  1  request valid from issue.
- ready_o  out  1  unit can accept a request this cycle.
- op_i  in  2  operation: 00 clz, 01 ctz, 10 cpop, 11 reserved.
- operand_i  in  XLEN  rs1 value.
- kill_i  in  1  flush: abort any in-flight operation.
- valid_o  out  1  result valid to writeback.
- ready_i  in  1  writeback accepts result.
- result_o  out  XLEN  count, zero-extended.

Behaviour:
- Reset: state=IDLE, valid_o=0, result_o=0, accumulator=0, chunk index=0. ready_o=0 while rst=1.
- States: IDLE, ENC, POP, DONE.
- IDLE:
  - ready_o=1.
  - Accept on valid_i & ready_o & ~kill_i.
  - Latch op.
  - Latch the operand into opnd_q: bit-reversed for ctz, unmodified otherwise.
  - Next state: clz/ctz -> ENC; cpop -> POP with acc=0, idx=0; reserved -> DONE with result_o=0.
- ENC:
  - One cycle. clz_encoder sees opnd_q combinationally.
  - result_o <= {zero-extend, out[5:0]}, range 0..32; an all-zero operand gives 32 for both clz and ctz.
  - Next state: DONE.
- POP:
  - Each cycle: acc <= acc + popcount(opnd_q[idx*POP_CHUNK +: POP_CHUNK]); idx increments.
  - After the last chunk (idx=XLEN/POP_CHUNK-1): result_o <= final sum, state DONE, idx wraps to 0.
  - acc width is 6 bits; the maximum sum is 32, so there is no overflow.
- DONE:
  - valid_o=1 and ready_o=0.
  - result_o is held stable until ready_i=1; on ready_i, valid_o drops the next cycle and state returns to IDLE.
  - No same-cycle re-accept (no bypass from DONE).
- Latency from the accept edge to valid_o high:
  - clz/ctz: 2 cycles.
  - cpop: XLEN/POP_CHUNK+1 cycles (5 at default).
  - reserved: 1 cycle.
- Throughput: one operation in flight.
- kill_i:
  - In any state: next state is IDLE, valid_o=0 next cycle, acc and idx cleared. result_o value is don't-care after kill but not X.
  - kill_i together with valid_i in IDLE: kill wins, the request is not accepted.
  - kill_i together with ready_i in DONE: treated as kill; the result is dropped.
- rst mid-operation: identical to the reset values above on the next edge; rst has priority over kill_i.
- Inputs op_i and operand_i are sampled only on the accept cycle; later changes are ignored.

Decomposition:
- Shared package zbb_pkg:
  - op encodings (OP_CLZ, OP_CTZ, OP_CPOP);
  - state enum;
  - XLEN constant;
  - COUNT_W=6 result-count width.
- Sub-modules:
  - Existing clz_encoder, instantiated once, unchanged.
  - One new combinational sub-module, popcnt_chunk, counting the set bits of a POP_CHUNK-wide slice.
- Bit reversal and the FSM stay inline.

Test Plan:
- clz 0x0001_0000 accepted at cycle 0 -> valid_o=1 at cycle 2, result_o=15. clz 0x8000_0000 -> 0. clz 0x0000_0000 -> 32.
- ctz 0x0000_0100 -> result 8 at cycle 2. ctz 0x0000_0000 -> 32. ctz 0x8000_0000 -> 31.
- cpop 0xF0F0_0001 -> valid_o at cycle 5, result 9. cpop 0xFFFF_FFFF -> 32. cpop 0 -> 0. ready_o=0 throughout cycles 1..5.
- Backpressure: clz 0x0000_00FF with ready_i held low 3 cycles after valid_o -> result_o stays 24 and valid_o stays 1 for those cycles; IDLE (ready_o=1) on the cycle after ready_i rises. op 11 -> result 0 at cycle 1.
- Abort cases:
  - kill_i at cycle 2 of cpop 0xFFFF_FFFF -> valid_o never asserts; ready_o=1 next cycle.
  - A following cpop 0x0000_000F -> 4 (accumulator cleared).
- Simultaneous events:
  - kill_i with valid_i in IDLE -> no accept, no valid_o.
  - rst asserted mid-ctz -> valid_o=0, result_o=0 next cycle.
  - A new clz 0x0000_0001 after reset -> 31.
